// File: rtl/cpupem_pkg.sv
// Shared types and field layout for the cpupem fetch path.
// Instruction word: operand address in [7:4], opcode in [3:0].
package cpupem_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam logic [3:0] OP_HALT_DEF = 4'hF;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 3;
    localparam int OPA_LSB = 4;
    localparam int OPA_MSB = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_WAIT,
        S_OPER,
        S_OPER_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Walks the program RAM: fetch instruction, read operand, hand the
// (opcode, operand) pair to the execute side over valid/ready.
module fetch_sequencer
    import cpupem_pkg::*;
#(
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter int         DATA_W  = DATA_W_DEF,
    parameter logic [3:0] OP_HALT = OP_HALT_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              exec_valid,
    input  logic              exec_ready,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] operando,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              halted
);

    state_t             state;
    logic [DATA_W-1:0]  instr;
    logic [ADDR_W-1:0]  opnd_addr;

    assign opnd_addr = ADDR_W'(instr[OPA_MSB:OPA_LSB]);

    // Strobe is a pure state decode so the RAM samples it in the issuing
    // cycle and the data lands in the *_WAIT state; hold gates it directly.
    assign ram_rd_en = !hold && (state == S_FETCH || state == S_OPER);
    assign ram_addr  = (state == S_OPER) ? opnd_addr : pc;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= S_IDLE;
            instr      <= '0;
            pc         <= '0;
            exec_valid <= 1'b0;
            opcode     <= '0;
            operando   <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc      <= '0;
                        running <= 1'b1;
                        halted  <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!hold) state <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    instr <= ram_rd_data;
                    if (ram_rd_data[OPC_MSB:OPC_LSB] == OP_HALT) begin
                        running <= 1'b0;
                        halted  <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state <= S_OPER;
                    end
                end
                S_OPER: begin
                    if (!hold) state <= S_OPER_WAIT;
                end
                S_OPER_WAIT: begin
                    operando   <= ram_rd_data;
                    opcode     <= instr[OPC_MSB:OPC_LSB];
                    exec_valid <= 1'b1;
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_ready) begin
                        exec_valid <= 1'b0;
                        pc         <= pc + ADDR_W'(1);
                        state      <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a 1-cycle-latency RAM model.
// Expected handshakes are derived from RAM contents before each start.
module tb_fetch_sequencer;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] ram_addr;
    logic       ram_rd_en;
    logic [7:0] ram_rd_data = 8'h00;
    logic       exec_valid;
    logic       exec_ready = 1'b0;
    logic [3:0] opcode;
    logic [7:0] operando;
    logic [3:0] pc;
    logic       running;
    logic       halted;

    logic [7:0]  mem [16];
    logic [15:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;

    fetch_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .hold        (hold),
        .ram_addr    (ram_addr),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_data (ram_rd_data),
        .exec_valid  (exec_valid),
        .exec_ready  (exec_ready),
        .opcode      (opcode),
        .operando    (operando),
        .pc          (pc),
        .running     (running),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (ram_rd_en) ram_rd_data <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (hold) check("rd_under_hold", {31'd0, ram_rd_en}, 32'd0);
            if (exec_valid && exec_ready) begin
                if (sb_q.size() == 0) begin
                    check("extra_exec", {31'd0, exec_valid}, 32'd0);
                end else begin
                    check("exec_pair", {16'd0, pc, opcode, operando},
                          {16'd0, sb_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    // Reference program walk: expected {pc, opcode, operand} per handshake.
    task automatic build_model(input int max_n);
        logic [3:0] p;
        logic [7:0] ins;
        sb_q.delete();
        p = 4'd0;
        for (int i = 0; i < max_n; i++) begin
            ins = mem[p];
            if (ins[3:0] == 4'hF) break;
            sb_q.push_back({p, ins[3:0], mem[ins[7:4]]});
            p = p + 4'd1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halted(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("sb_drained", sb_q.size(), 32'd0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!exec_valid && n < budget) begin
            tick();
            n++;
        end
        check("valid_seen", {31'd0, exec_valid}, 32'd1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        sb_q.delete();
    endtask

    initial begin
        clear_mem(8'h00);

        // Reset with start held high: start must be ignored.
        resetn = 1'b0;
        start = 1'b1;
        tick();
        tick();
        check("rst_outs", {ram_addr, ram_rd_en, exec_valid, opcode,
                           operando, pc, running, halted}, 32'd0);
        start = 1'b0;
        resetn = 1'b1;
        tick();
        check("idle_quiet", {running, halted, ram_rd_en}, 32'd0);

        // Basic run with latency check.
        clear_mem(8'h00);
        mem[0] = 8'h31;
        mem[1] = 8'h0F;
        mem[3] = 8'hA5;
        build_model(32);
        exec_ready = 1'b1;
        pulse_start();
        check("running", {31'd0, running}, 32'd1);
        tick();
        tick();
        tick();
        check("lat_early", {31'd0, exec_valid}, 32'd0);
        tick();
        check("lat_valid", {31'd0, exec_valid}, 32'd1);
        wait_halted(50);
        check("halt_run", {running, halted}, 32'd1);
        check("halt_pc", {28'd0, pc}, 32'd1);
        repeat (6) tick();
        check("basic_drain", sb_q.size(), 32'd0);

        // Backpressure: pair must stay stable while exec_ready is low.
        clear_mem(8'h00);
        mem[0] = 8'h52;
        mem[1] = 8'h0F;
        mem[5] = 8'h3C;
        build_model(32);
        exec_ready = 1'b0;
        pulse_start();
        wait_valid(20);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_stable", {exec_valid, opcode, operando, pc},
                  {1'b1, 4'h2, 8'h3C, 4'h0});
        end
        exec_ready = 1'b1;
        tick();
        check("bp_accept", {27'd0, exec_valid, pc}, 32'd1);
        wait_halted(50);

        // Hold during FETCH: no read until release, then at pc 0.
        clear_mem(8'h00);
        mem[0] = 8'h64;
        mem[1] = 8'h0F;
        mem[6] = 8'h77;
        build_model(32);
        hold = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            check("hold_rd", {31'd0, ram_rd_en}, 32'd0);
            tick();
        end
        hold = 1'b0;
        #1;
        check("hold_release", {27'd0, ram_rd_en, ram_addr}, 32'h10);
        wait_halted(50);
        repeat (4) tick();
        check("hold_drain", sb_q.size(), 32'd0);

        // Wrap: never halts, pc runs 15 -> 0 and continues.
        clear_mem(8'h12);
        build_model(20);
        exec_ready = 1'b1;
        pulse_start();
        wait_drain(300);
        check("wrap_run", {31'd0, running}, 32'd1);
        do_reset();

        // Reset while a pair is pending.
        exec_ready = 1'b0;
        pulse_start();
        wait_valid(20);
        resetn = 1'b0;
        tick();
        check("rst_exec", {exec_valid, pc, opcode, running, halted},
              32'd0);
        resetn = 1'b1;
        tick();
        build_model(2);
        exec_ready = 1'b1;
        pulse_start();
        wait_drain(40);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch reader for the 16×8 program RAM, complementing the switch-driven loader that writes it. After a start pulse it walks the program counter through RAM and reads each instruction word. Each word splits into an operand address and a 4-bit opcode. The block then reads the operand word and hands the (opcode, operand) pair to the ULA/control path through a valid/ready handshake. It sits between `ram` (read side) and `ucontrol`/`ula`, and yields the RAM to the loader whenever write mode is active.

## Interface
Parameters:
- ADDR_W, 4, RAM address width (depth 2^ADDR_W)
- DATA_W, 8, RAM word width
- OP_HALT, 4'hF, opcode that stops execution

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution at address 0
- hold  in  1  loader active (SW[8]); sequencer must not drive reads
- ram_addr  out  ADDR_W  RAM read address
- ram_rd_en  out  1  read strobe
- ram_rd_data  in  DATA_W  RAM data, valid exactly 1 cycle after ram_rd_en
- exec_valid  out  1  opcode/operando valid for ULA
- exec_ready  in  1  ULA accepts pair
- opcode  out  4  instruction[3:0]
- operando  out  DATA_W  word at mem[instruction[7:4]]
- pc  out  ADDR_W  address of current instruction
- running  out  1  high from start until HALT or reset
- halted  out  1  high after HALT opcode is fetched

## Operation
- Reset (resetn=0 at a clock edge): state IDLE. All outputs are 0: pc, ram_addr, ram_rd_en, exec_valid, opcode, operando, running, halted. Reset mid-operation aborts immediately with no pending handshake.
- FSM states:
  - IDLE: wait for start. On start, pc←0, running←1, halted←0, go to FETCH. start is ignored in every other state.
  - FETCH: if hold=1, stay and keep ram_rd_en=0. Otherwise ram_addr←pc, ram_rd_en=1 for one cycle, go to FETCH_WAIT.
  - FETCH_WAIT: latch instr←ram_rd_data.
    - If instr[3:0]==OP_HALT: go to HALT; no operand read, no exec_valid.
    - Otherwise go to OPER.
  - OPER: if hold=1, stay. Otherwise ram_addr←instr[7:4], ram_rd_en=1, go to OPER_WAIT.
  - OPER_WAIT: operando←ram_rd_data, opcode←instr[3:0], exec_valid←1, go to EXEC.
  - EXEC: hold exec_valid, opcode and operando stable until exec_ready=1. On the accept cycle: exec_valid←0, pc←pc+1, go to FETCH.
  - HALT: running←0, halted←1. On start, restart as from IDLE.
- pc arithmetic is modulo 2^ADDR_W: 15+1 wraps to 0, with no halt on wrap.
- hold does not interrupt EXEC; the handshake completes regardless.
- An operand address equal to pc is legal; the instruction reads its own word.
- ram_rd_en is never asserted while hold=1.

## Timing
- RAM read latency is fixed at 1 cycle; data is sampled in the *_WAIT state.
- Minimum instruction time is 5 cycles (FETCH, FETCH_WAIT, OPER, OPER_WAIT, EXEC with exec_ready already high).
- exec_valid rises on the clock edge leaving OPER_WAIT, and falls on the edge after exec_ready is sampled high.
- When hold is released, the read issues on the next edge.
- If start and resetn=0 occur in the same cycle, reset wins.
- If exec_ready is high in the same cycle exec_valid first rises, the pair is accepted that cycle.

## Structure
- Shared package `cpupem_pkg`: the state enum (IDLE, FETCH, FETCH_WAIT, OPER, OPER_WAIT, EXEC, HALT), OP_HALT, ADDR_W/DATA_W defaults, and field positions for opcode [3:0] and operand address [7:4].
- Single module; no sub-module.
- Optional `pc_counter` (wrapping ADDR_W counter with load-zero and increment) if the loader reuses it.

## Test plan
- Reset: hold resetn=0 for 2 cycles → every output is 0, state IDLE; start is ignored while resetn=0.
- Basic run: mem[0]=8'h31, mem[1]=8'h0F, mem[3]=8'hA5, pulse start with exec_ready=1 → one handshake (opcode=1, operando=8'hA5, pc=0) 4 cycles after FETCH. Then halted=1, running=0, and no second exec_valid.
- Backpressure: exec_ready=0 for 6 cycles → exec_valid, opcode and operando stay constant. pc advances only on the cycle after exec_ready rises.
- Hold: assert hold while in FETCH for 3 cycles → ram_rd_en stays 0 throughout. The read issues 1 cycle after release at the unchanged pc.
- Wrap: fill mem with a non-HALT opcode and exec_ready=1 → pc goes 15→0 and execution continues.
- Reset mid-EXEC: with exec_valid=1, drive resetn=0 → next edge exec_valid=0, pc=0, state IDLE. A subsequent start re-executes from address 0.
